// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M-style multiply/divide unit: single-cycle product, radix-2 restoring divide.
// Latency: MUL ops done two cycles after accept, divides DATA_W+1 (specials 2 when OPT_FAST_SPECIAL=1).
// No backpressure: start is only sampled in IDLE; flush or rst abandons the op without a done pulse.
module muldiv_unit #(
  parameter int DATA_W           = 32,
  parameter bit OPT_FAST_SPECIAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;        // raw src1 (multiplicand, special-case results)
  logic [DATA_W-1:0]  b_q, b_d;        // raw src2 (multiplier)
  logic [DATA_W-1:0]  quo_q, quo_d;    // dividend magnitude shifting out, quotient shifting in
  logic [DATA_W-1:0]  rem_q, rem_d;    // partial remainder
  logic [DATA_W-1:0]  dvs_q, dvs_d;    // divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d;  // negate quotient at the end
  logic               rneg_q, rneg_d;  // negate remainder at the end
  logic               dz_q, dz_d;      // divide by zero
  logic               spec_q, spec_d;  // divide by zero or signed overflow
  logic [DATA_W-1:0]  result_q, result_d;

  // Operand decode at accept time: magnitudes and special-case detection for divides
  logic               div_signed, sign1, sign2, src2_zero, div_ovf;
  logic [DATA_W-1:0]  mag1, mag2;
  assign div_signed = ~funct3[0];
  assign sign1      = div_signed & src1[DATA_W-1];
  assign sign2      = div_signed & src2[DATA_W-1];
  assign mag1       = sign1 ? -src1 : src1;
  assign mag2       = sign2 ? -src2 : src2;
  assign src2_zero  = (src2 == '0);
  assign div_ovf    = div_signed && (src1 == MOST_NEG) && (src2 == '1);

  // Multiply: sign-extend both operands to 2*DATA_W so one unsigned multiplier covers all signedness mixes
  logic                a_sgn, b_sgn;
  logic [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [DATA_W-1:0]   mul_res;
  assign a_sgn   = (op_q == 3'b001) || (op_q == 3'b010);
  assign b_sgn   = (op_q == 3'b001);
  assign a_ext   = {{DATA_W{a_sgn & a_q[DATA_W-1]}}, a_q};
  assign b_ext   = {{DATA_W{b_sgn & b_q[DATA_W-1]}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_q == 3'b000) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];

  // One restoring step; bit DATA_W of the difference is the borrow whenever the divisor is nonzero
  logic [DATA_W:0]    rem_sh, rem_sub;
  logic               ge;
  logic [DATA_W-1:0]  rem_nx, quo_nx, q_fin, r_fin, div_res;
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign ge      = ~rem_sub[DATA_W];
  assign rem_nx  = ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quo_nx  = {quo_q[DATA_W-2:0], ge};
  assign q_fin   = spec_q ? (dz_q ? '1 : a_q) : (qneg_q ? -quo_nx : quo_nx);
  assign r_fin   = spec_q ? (dz_q ? a_q : '0) : (rneg_q ? -rem_nx : rem_nx);
  assign div_res = op_q[1] ? r_fin : q_fin;

  // Next-state and datapath control; flush overrides everything and leaves result untouched
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    spec_d   = spec_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = funct3;
          a_d     = src1;
          b_d     = src2;
          quo_d   = mag1;
          dvs_d   = mag2;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = sign1 ^ sign2;
          rneg_d  = sign1;
          dz_d    = src2_zero;
          spec_d  = src2_zero | div_ovf;
          state_d = funct3[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        result_d = mul_res;
        state_d  = S_DONE;
      end
      S_DIV: begin
        if (OPT_FAST_SPECIAL && spec_q) begin
          result_d = div_res;
          state_d  = S_DONE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            result_d = div_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      spec_q   <= spec_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (32-bit fast specials, 32-bit iterated specials, 16-bit).
// Expected results and done edges are queued at issue; a monitor pops on every done pulse.
// Only one instance is active at a time, so a single ordered queue serves all three.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        st [3];
  logic [2:0]  f3 [3];
  logic [63:0] s1 [3];
  logic [63:0] s2 [3];
  logic        fl [3];
  logic        bz [3];
  logic        dn [3];
  logic [63:0] rs [3];

  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] r0, r1;
  logic [15:0] r2;

  muldiv_unit #(.DATA_W(32), .OPT_FAST_SPECIAL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .start(st[0]), .funct3(f3[0]), .src1(s1[0][31:0]), .src2(s2[0][31:0]),
    .flush(fl[0]), .busy(busy0), .done(done0), .result(r0));
  muldiv_unit #(.DATA_W(32), .OPT_FAST_SPECIAL(1'b0)) u_slow (
    .clk(clk), .rst(rst), .start(st[1]), .funct3(f3[1]), .src1(s1[1][31:0]), .src2(s2[1][31:0]),
    .flush(fl[1]), .busy(busy1), .done(done1), .result(r1));
  muldiv_unit #(.DATA_W(16), .OPT_FAST_SPECIAL(1'b1)) u_w16 (
    .clk(clk), .rst(rst), .start(st[2]), .funct3(f3[2]), .src1(s1[2][15:0]), .src2(s2[2][15:0]),
    .flush(fl[2]), .busy(busy2), .done(done2), .result(r2));

  assign bz[0] = busy0;
  assign bz[1] = busy1;
  assign bz[2] = busy2;
  assign dn[0] = done0;
  assign dn[1] = done1;
  assign dn[2] = done2;
  assign rs[0] = {32'b0, r0};
  assign rs[1] = {32'b0, r1};
  assign rs[2] = {48'b0, r2};

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  typedef struct {
    int          id;
    logic [63:0] res;
    int          edge_n;
    string       nm;
  } exp_t;

  exp_t        exq [$];
  exp_t        mon_e;
  logic [63:0] last_res [3];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          checks++;
          if (exq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done inst=%0d: got done with result %h want no done", i, rs[i]);
          end else begin
            mon_e = exq.pop_front();
            if (mon_e.id != i || rs[i] !== mon_e.res) begin
              errors++;
              $display("FAIL %s result: got %h on inst %0d want %h on inst %0d",
                       mon_e.nm, rs[i], i, mon_e.res, mon_e.id);
            end
            checks++;
            if (cyc + 1 != mon_e.edge_n) begin
              errors++;
              $display("FAIL %s latency: got done sampled at edge %0d want edge %0d",
                       mon_e.nm, cyc + 1, mon_e.edge_n);
            end
          end
        end
      end
    end
  end

  // Caller is at a negedge; the accept edge is the next posedge. Returns at the following negedge.
  task automatic issue(input int id, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input int lat, input string nm, input bit expect_done);
    exp_t e;
    st[id] = 1'b1;
    f3[id] = f;
    s1[id] = a;
    s2[id] = b;
    if (expect_done) begin
      e.id     = id;
      e.res    = res;
      e.edge_n = cyc + 1 + lat;
      e.nm     = nm;
      exq.push_back(e);
      last_res[id] = res;
    end
    @(negedge clk);
    st[id] = 1'b0;
  endtask

  task automatic wait_idle(input int id, input int budget, input string nm);
    int k = 0;
    while ((bz[id] || exq.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s timeout: got still busy after %0d cycles want idle", nm, budget);
      exq.delete();
    end
  endtask

  task automatic run(input int id, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] res, input int lat, input string nm);
    issue(id, f, a, b, res, lat, nm, 1'b1);
    wait_idle(id, 60, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; f3[i] = 3'b0; s1[i] = '0; s2[i] = '0; fl[i] = 1'b0; last_res[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy%0d", i), {63'b0, bz[i]}, 64'd0);
      chk($sformatf("reset_done%0d", i), {63'b0, dn[i]}, 64'd0);
      chk($sformatf("reset_result%0d", i), rs[i], 64'd0);
    end

    // First start presented on the first rising edge after release
    rst = 1'b0;
    run(0, MULH,   64'h80000000, 64'h80000000, 64'h40000000, 2,  "mulh_neg_sq");
    run(0, MUL,    64'h80000000, 64'h80000000, 64'h00000000, 2,  "mul_neg_sq");
    run(0, MULHSU, 64'hFFFFFFFF, 64'h00000002, 64'hFFFFFFFF, 2,  "mulhsu_m1x2");
    run(0, MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 2,  "mulhu_max");
    run(0, MULH,   64'h40000000, 64'h00000004, 64'h00000001, 2,  "mulh_pos");
    run(0, MUL,    64'h12345678, 64'h00000010, 64'h23456780, 2,  "mul_low");
    run(0, DIV,    64'hFFFFFFF9, 64'h00000002, 64'hFFFFFFFD, 33, "div_m7_2");
    run(0, REM,    64'hFFFFFFF9, 64'h00000002, 64'hFFFFFFFF, 33, "rem_m7_2");
    run(0, DIVU,   64'h00000064, 64'h00000007, 64'h0000000E, 33, "divu_100_7");
    run(0, REMU,   64'h00000064, 64'h00000007, 64'h00000002, 33, "remu_100_7");
    run(0, DIVU,   64'h00000005, 64'h00000000, 64'hFFFFFFFF, 2,  "divu_by0");
    run(0, REMU,   64'h00000005, 64'h00000000, 64'h00000005, 2,  "remu_by0");
    run(0, DIV,    64'hFFFFFFF9, 64'h00000000, 64'hFFFFFFFF, 2,  "div_by0_neg");
    run(0, REM,    64'h80000000, 64'hFFFFFFFF, 64'h00000000, 2,  "rem_ovf");
    run(0, DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2,  "div_ovf");
    run(0, REM,    64'h00000007, 64'hFFFFFFFE, 64'h00000001, 33, "rem_7_m2");

    // Flush mid-divide; starts presented while busy must be ignored
    issue(0, DIV, 64'h00000064, 64'h00000007, 64'h0, 33, "flushed_div", 1'b0);
    repeat (3) begin
      st[0] = 1'b1; f3[0] = MUL; s1[0] = 64'h3; s2[0] = 64'h5;
      @(negedge clk);
    end
    st[0] = 1'b0;
    repeat (5) @(negedge clk);
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    chk("flush_busy", {63'b0, bz[0]}, 64'd0);
    chk("flush_result_kept", rs[0], last_res[0]);
    repeat (40) @(negedge clk);
    chk("flush_no_restart", {63'b0, bz[0]}, 64'd0);

    // Start together with flush in IDLE is rejected
    st[0] = 1'b1; fl[0] = 1'b1; f3[0] = DIVU; s1[0] = 64'h9; s2[0] = 64'h2;
    @(negedge clk);
    st[0] = 1'b0; fl[0] = 1'b0;
    chk("start_flush_rejected", {63'b0, bz[0]}, 64'd0);
    repeat (5) @(negedge clk);

    // Slow-special instance: specials iterate the full DATA_W cycles
    run(1, DIVU, 64'h00000005, 64'h00000000, 64'hFFFFFFFF, 33, "slow_divu_by0");
    run(1, REM,  64'h80000000, 64'hFFFFFFFF, 64'h00000000, 33, "slow_rem_ovf");
    run(1, DIV,  64'hFFFFFFF9, 64'h00000002, 64'hFFFFFFFD, 33, "slow_div_m7_2");

    // 16-bit instance
    run(2, DIVU,  64'hFFFF, 64'h0003, 64'h5555, 17, "w16_divu");
    run(2, MULHU, 64'hFFFF, 64'hFFFF, 64'hFFFE, 2,  "w16_mulhu");
    run(2, DIV,   64'h8000, 64'hFFFF, 64'h8000, 2,  "w16_div_ovf");

    // Asynchronous reset mid-divide
    issue(0, DIV, 64'hFFFFFFF9, 64'h00000002, 64'h0, 33, "reset_div", 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst_busy%0d", i), {63'b0, bz[i]}, 64'd0);
      chk($sformatf("async_rst_done%0d", i), {63'b0, dn[i]}, 64'd0);
      chk($sformatf("async_rst_result%0d", i), rs[i], 64'd0);
      last_res[i] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", {63'b0, bz[0]}, 64'd0);
    run(0, DIVU, 64'h00000064, 64'h00000007, 64'h0000000E, 33, "post_rst_divu");

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
